conv_output_feeder: RTL

Stream transmitter that drives the 64-bit sData/sValid/sReady input of the convolution output stage from a synchronous-read result buffer. On a start pulse it latches the layer geometry (In_Channel, Matrix_Col, Matrix_Row), walks the buffer in pixel-major, channel-fastest order, and emits one 8-byte beat per 8 channels of a pixel. A 2-entry skid FIFO absorbs the 1-cycle buffer read latency, so throughput is one beat per cycle under continuous mReady. The block marks the final beat of the layer with mLast.

---
 rtl/conv_output_feeder_pkg.sv | 20 ++
 rtl/conv_output_feeder_if.sv | 12 +
 rtl/conv_feeder_skid_fifo.sv | 61 ++++++
 rtl/conv_output_feeder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/conv_output_feeder_pkg.sv
// Shared types, constants and the layer geometry check for the convolution output feeder.
package conv_output_feeder_pkg;

  localparam int unsigned DATA_WIDTH     = 64;
  localparam int unsigned BYTES_PER_BEAT = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  // Channels must fill whole beats; every dimension must be non-empty.
  function automatic logic geom_ok(input logic [31:0] ch, input logic [31:0] col,
                                   input logic [31:0] row);
    return ((ch % BYTES_PER_BEAT) == 32'd0) && (ch != 32'd0) && (col != 32'd0) &&
           (row != 32'd0);
  endfunction

endpackage

// File: rtl/conv_output_feeder_if.sv
// Valid/ready beat stream carrying one 8-channel pixel slice per beat, with an end-of-layer flag.
interface conv_output_feeder_if #(
  parameter int unsigned DATA_WIDTH = conv_output_feeder_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] mData;
  logic                  mValid;
  logic                  mReady;
  logic                  mLast;

  modport master (output mData, output mValid, output mLast, input mReady);
  modport slave  (input mData, input mValid, input mLast, output mReady);
endinterface

// File: rtl/conv_feeder_skid_fifo.sv
// Two-entry FIFO absorbing the one-cycle buffer read latency; head is a register.
module conv_feeder_skid_fifo #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) mem0_d = din_i;
        else               mem1_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        mem0_d = mem1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; when full the tail slides into the head.
        if (cnt_q == 2'd2) begin
          mem0_d = mem1_q;
          mem1_d = din_i;
        end else begin
          mem0_d = din_i;
        end
      end
      default: ;
    endcase
    if (clear_i) cnt_d = 2'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem0_q;

endmodule

// File: rtl/conv_output_feeder.sv
// Walks a layer's result buffer pixel-major / channel-fastest and streams one beat per 8 channels.
module conv_output_feeder
  import conv_output_feeder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned CH_WIDTH   = 12,
  parameter int unsigned DIM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CH_WIDTH-1:0]   In_Channel,
  input  logic [DIM_WIDTH-1:0]  Matrix_Col,
  input  logic [DIM_WIDTH-1:0]  Matrix_Row,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  conv_output_feeder_if.master  m_if,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int unsigned GrpW = CH_WIDTH - 3;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, total_q, issue_cnt_q, pop_cnt_q;
  logic [GrpW-1:0]       grp_max_q, ch_grp_q;
  logic [DIM_WIDTH-1:0]  col_max_q, row_max_q, col_q, row_q;
  logic                  inflight_q, done_q, cfg_err_q;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic                  pop, idle, start_ok, start_bad, last_issue, last_pop;

  assign idle      = (state_q == StIdle);
  assign start_ok  = start && idle && geom_ok(32'(In_Channel), 32'(Matrix_Col), 32'(Matrix_Row));
  assign start_bad = start && idle && !start_ok;

  assign pop        = m_if.mValid && m_if.mReady;
  assign m_if.mValid = (fifo_count != 2'd0);
  assign m_if.mLast  = m_if.mValid && (pop_cnt_q == total_q - ADDR_WIDTH'(1));
  assign last_pop    = pop && m_if.mLast;

  // Entries held plus the read in flight, less what leaves this cycle, must stay below 2.
  assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign rd_en     = (state_q == StIssue) && (occupancy < 3'd2);
  assign rd_addr   = base_q + issue_cnt_q;

  assign last_issue = (ch_grp_q == grp_max_q) && (col_q == col_max_q) && (row_q == row_max_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StIssue;
      StIssue: if (rd_en && last_issue) state_d = StDrain;
      StDrain: if (last_pop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      total_q     <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      grp_max_q   <= '0;
      ch_grp_q    <= '0;
      col_max_q   <= '0;
      row_max_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      done_q     <= (state_q == StDrain) && last_pop;
      cfg_err_q  <= start_bad;
      if (start_ok) begin
        base_q      <= base_addr;
        total_q     <= ADDR_WIDTH'(Matrix_Row) * ADDR_WIDTH'(Matrix_Col) *
                       ADDR_WIDTH'(In_Channel[CH_WIDTH-1:3]);
        grp_max_q   <= In_Channel[CH_WIDTH-1:3] - GrpW'(1);
        col_max_q   <= Matrix_Col - DIM_WIDTH'(1);
        row_max_q   <= Matrix_Row - DIM_WIDTH'(1);
        issue_cnt_q <= '0;
        pop_cnt_q   <= '0;
        ch_grp_q    <= '0;
        col_q       <= '0;
        row_q       <= '0;
      end else begin
        if (rd_en) begin
          issue_cnt_q <= issue_cnt_q + ADDR_WIDTH'(1);
          if (ch_grp_q == grp_max_q) begin
            ch_grp_q <= '0;
            if (col_q == col_max_q) begin
              col_q <= '0;
              row_q <= row_q + DIM_WIDTH'(1);
            end else begin
              col_q <= col_q + DIM_WIDTH'(1);
            end
          end else begin
            ch_grp_q <= ch_grp_q + GrpW'(1);
          end
        end
        if (pop) pop_cnt_q <= pop_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  conv_feeder_skid_fifo #(
    .Width(DATA_WIDTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .clear_i(start_ok),
    .push_i (inflight_q),
    .din_i  (rd_data),
    .pop_i  (pop),
    .count_o(fifo_count),
    .head_o (m_if.mData)
  );

  assign busy    = !idle;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule
